odometer_capture_fifo: RTL and testbench
========================================

// Module: odometer_capture_fifo
// PURPOSE
//  Next-generation beat-count capture for the stacked odometer. Runs on a clock and has a parameterised width.
//  - On each DETECT falling edge, samples BF_COUNTER and pushes it into a DEPTH-entry FIFO.
//  - An internal deadzone timer replaces the external MSB input; on expiry it pushes the all-ones saturation code.
//  - Readout uses an RD_EN/RD_VALID handshake, so back-to-back detections are kept until read instead of overwritten.
// PARAMETERS
//  CNT_W   12  width of BF_COUNTER and of each captured entry
//  DEPTH   4   FIFO entries; power of 2, >=2
//  DZ_W    10  deadzone timer width; timeout after 2^DZ_W-1 armed cycles with no detection
// PORTS
//  CLK         in   1                 capture/readout clock
//  RESETB      in   1                 reset, asynchronous, active-low
//  DETECT      in   1                 asynchronous detector pulse; capture on falling edge
//  BF_COUNTER  in   CNT_W             free-running beat count, sampled on the capture cycle
//  ARM         in   1                 1 = captures and deadzone timer enabled
//  RD_EN       in   1                 pop request
//  RD_DATA     out  CNT_W             popped entry
//  RD_VALID    out  1                 1-cycle strobe qualifying RD_DATA
//  EMPTY       out  1                 FIFO holds 0 entries
//  FULL        out  1                 FIFO holds DEPTH entries
//  LEVEL       out  $clog2(DEPTH)+1   current entry count
//  OVERFLOW    out  1                 sticky; an event was dropped while full
//  CLR_OVF     in   1                 synchronous clear of OVERFLOW
// BEHAVIOUR
//  - Reset (async assert, sync to CLK on release). All outputs 0 except EMPTY=1.
//    Clears sync flops, deadzone timer and pointers. FIFO contents become don't-care.
//  - DETECT path: 2-FF synchroniser, then a 3rd flop for edge detect. fall_evt = d_q2 & ~d_q1.
//    Latency from DETECT fall to push is 3 CLK.
//    The history flops reset to 0, so no false edge occurs after reset.
//  - Capture event (ARM & fall_evt): push BF_COUNTER as sampled in the fall_evt cycle. The deadzone timer clears to 0.
//  - Deadzone timer: while ARM & ~fall_evt, increments each cycle.
//    On reaching 2^DZ_W-1 it raises timeout_evt, pushes {CNT_W{1'b1}}, and wraps to 0.
//  - fall_evt and timeout_evt in the same cycle: only the capture is pushed, and the timer clears.
//  - ARM=0: timer held at 0, events ignored, FIFO retained, reads still served.
//    Pushes are gated on ARM in the same cycle.
//  - Push when FULL without a same-cycle pop: entry dropped, OVERFLOW<=1, FIFO unchanged.
//  - Push when FULL with a same-cycle pop: both succeed, LEVEL unchanged, OVERFLOW unchanged.
//  - Pop: RD_EN & ~EMPTY. On the next CLK RD_DATA = oldest entry and RD_VALID=1 for one cycle.
//    RD_DATA holds its value after that cycle.
//  - RD_EN when EMPTY is ignored: RD_VALID=0, no pointer move.
//  - Push into EMPTY with a same-cycle RD_EN: the pop is ignored and the entry is readable from the next cycle.
//    There is no fall-through.
//  - CLR_OVF has priority over a same-cycle overflow set, so OVERFLOW ends at 0.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. LEVEL = pushes - pops, in the range 0..DEPTH.
// CONFIGURATION
//  - Macro ODO_TIMEOUT_TAG_EN.
//  - When defined: each entry is CNT_W+1 bits and stores the tag (1 = deadzone saturation entry, 0 = real capture).
//    Extra output port RD_TIMEOUT (out, 1 bit) is valid with RD_VALID and resets to 0.
//  - When not defined: the port is absent and entries are CNT_W bits.
//    A saturation entry is then indistinguishable from a genuine all-ones count.
// TESTING
//  1. Reset: assert RESETB=0 mid-operation with LEVEL=3 -> EMPTY=1, LEVEL=0, RD_VALID=0, OVERFLOW=0 immediately.
//  2. Single capture: ARM=1, BF_COUNTER=12'h2A5, DETECT 1->0.
//     -> LEVEL=1 three CLK after the fall.
//     -> RD_EN pulse gives RD_DATA=12'h2A5 with RD_VALID=1 on the next cycle.
//  3. Deadzone timeout: DZ_W=4, ARM=1, no DETECT for 15 cycles.
//     -> push 12'hFFF, with RD_TIMEOUT=1 when ODO_TIMEOUT_TAG_EN is defined.
//     -> timer restarts; a second 12'hFFF follows 15 cycles later.
//  4. Overflow: DEPTH=4, 5 detections with counts 1..5 and no reads.
//     -> FULL=1, OVERFLOW=1; reads return 1,2,3,4.
//     -> CLR_OVF gives OVERFLOW=0.
//  5. Full with simultaneous push and pop: FULL, RD_EN=1 in the fall_evt cycle.
//     -> LEVEL stays 4, OVERFLOW stays 0, newest entry is read last.
//  6. Collision and disarm: fall_evt in the same cycle as timer expiry -> only the BF_COUNTER value is pushed.
//     ARM=0 then a DETECT fall -> no push, and LEVEL is unchanged.

Source files
------------

// File: rtl/odometer_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : odometer_capture_fifo
//  Purpose  : Beat-count capture for the stacked odometer. Each falling edge
//             of the asynchronous DETECT pulse samples BF_COUNTER into a
//             DEPTH-entry FIFO. An internal deadzone timer pushes the
//             all-ones saturation code when no detection arrives within
//             2^DZ_W-1 armed cycles. Entries are drained through an
//             RD_EN / RD_VALID handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CNT_W  width of BF_COUNTER and of each captured count
//    DEPTH  FIFO entries (power of 2, >= 2)
//    DZ_W   deadzone timer width
//  Configuration macro
//    ODO_TIMEOUT_TAG_EN  when defined, each entry carries a timeout tag and
//                        the RD_TIMEOUT output is present
//  Ports
//    CLK         in   capture / readout clock
//    RESETB      in   asynchronous active-low reset
//    DETECT      in   asynchronous detector pulse, captured on falling edge
//    BF_COUNTER  in   free-running beat count
//    ARM         in   enables captures and the deadzone timer
//    RD_EN       in   pop request
//    CLR_OVF     in   synchronous clear of OVERFLOW
//    RD_DATA     out  popped entry (held after the RD_VALID cycle)
//    RD_VALID    out  one-cycle strobe qualifying RD_DATA
//    RD_TIMEOUT  out  (tag build only) popped entry is a saturation code
//    EMPTY       out  FIFO holds no entries
//    FULL        out  FIFO holds DEPTH entries
//    LEVEL       out  current entry count, 0..DEPTH
//    OVERFLOW    out  sticky: an event was dropped while full
// ============================================================================
module odometer_capture_fifo #(
  parameter int CNT_W = 12,
  parameter int DEPTH = 4,
  parameter int DZ_W  = 10
) (
  input  logic                       CLK,
  input  logic                       RESETB,
  input  logic                       DETECT,
  input  logic [CNT_W-1:0]           BF_COUNTER,
  input  logic                       ARM,
  input  logic                       RD_EN,
  input  logic                       CLR_OVF,
  output logic [CNT_W-1:0]           RD_DATA,
  output logic                       RD_VALID,
`ifdef ODO_TIMEOUT_TAG_EN
  output logic                       RD_TIMEOUT,
`endif
  output logic                       EMPTY,
  output logic                       FULL,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       OVERFLOW
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef ODO_TIMEOUT_TAG_EN
  localparam int ENT_W = CNT_W + 1;
`else
  localparam int ENT_W = CNT_W;
`endif

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = '0;
  // The increment that would land on 2^DZ_W-1 is the one that expires.
  localparam logic [DZ_W-1:0]  DZ_LAST  = {{(DZ_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] SAT_CODE = '1;

  // --------------------------------------------------------------------------
  // DETECT synchroniser and falling-edge detect
  // --------------------------------------------------------------------------
  // d_q0/d_q1 form the synchroniser; d_q2 is the history flop. All reset to
  // 0 so releasing reset can never look like a falling edge.
  logic d_q0;
  logic d_q1;
  logic d_q2;
  logic fall_evt;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      d_q0 <= 1'b0;
      d_q1 <= 1'b0;
      d_q2 <= 1'b0;
    end else begin
      d_q0 <= DETECT;
      d_q1 <= d_q0;
      d_q2 <= d_q1;
    end
  end

  assign fall_evt = d_q2 & ~d_q1;

  // --------------------------------------------------------------------------
  // Deadzone timer
  // --------------------------------------------------------------------------
  logic [DZ_W-1:0] dz_timer;
  logic            timeout_evt;
  logic            capture_evt;

  assign capture_evt = ARM & fall_evt;
  // A same-cycle capture wins over expiry, so timeout is masked by fall_evt.
  assign timeout_evt = ARM & ~fall_evt & (dz_timer == DZ_LAST);

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      dz_timer <= '0;
    end else if (!ARM || fall_evt || timeout_evt) begin
      dz_timer <= '0;
    end else begin
      dz_timer <= dz_timer + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Push / pop qualification
  // --------------------------------------------------------------------------
  logic [LVL_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             is_empty;
  logic             is_full;
  logic             push_req;
  logic             push_ok;
  logic             pop_ok;
  logic             ovf_set;
  logic [ENT_W-1:0] push_entry;

  assign is_empty = (count == LVL_ZERO);
  assign is_full  = (count == LVL_FULL);
  assign push_req = capture_evt | timeout_evt;
  // No fall-through: a pop needs an entry already stored before this cycle.
  assign pop_ok   = RD_EN & ~is_empty;
  // When full, a same-cycle pop frees the slot the push writes into.
  assign push_ok  = push_req & (~is_full | pop_ok);
  assign ovf_set  = push_req & is_full & ~pop_ok;

`ifdef ODO_TIMEOUT_TAG_EN
  assign push_entry = capture_evt ? {1'b0, BF_COUNTER} : {1'b1, SAT_CODE};
`else
  assign push_entry = capture_evt ? BF_COUNTER : SAT_CODE;
`endif

  // --------------------------------------------------------------------------
  // Storage (contents are don't-care after reset, so no reset term)
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, level and overflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      OVERFLOW <= 1'b0;
    end else if (CLR_OVF) begin
      OVERFLOW <= 1'b0;
    end else if (ovf_set) begin
      OVERFLOW <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read port: registered data, held between pops
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0] rd_entry;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      rd_entry <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= pop_ok;
      if (pop_ok) begin
        rd_entry <= mem[rd_ptr];
      end
    end
  end

`ifdef ODO_TIMEOUT_TAG_EN
  assign RD_DATA    = rd_entry[CNT_W-1:0];
  assign RD_TIMEOUT = rd_entry[CNT_W];
`else
  assign RD_DATA    = rd_entry;
`endif

  assign EMPTY = is_empty;
  assign FULL  = is_full;
  assign LEVEL = count;

endmodule
`default_nettype wire

// File: tb/tb_odometer_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_odometer_capture_fifo
//  Purpose  : Directed self-checking bench for odometer_capture_fifo with
//             CNT_W=12, DEPTH=4, DZ_W=4 (deadzone expiry every 15 cycles).
//  Revision : 1.0  initial release
// ============================================================================
module tb_odometer_capture_fifo;

  localparam int CNT_W = 12;
  localparam int DEPTH = 4;
  localparam int DZ_W  = 4;

  logic              CLK = 1'b0;
  logic              RESETB = 1'b0;
  logic              DETECT = 1'b0;
  logic [CNT_W-1:0]  BF_COUNTER = '0;
  logic              ARM = 1'b0;
  logic              RD_EN = 1'b0;
  logic              CLR_OVF = 1'b0;
  logic [CNT_W-1:0]  RD_DATA;
  logic              RD_VALID;
  logic              EMPTY;
  logic              FULL;
  logic [2:0]        LEVEL;
  logic              OVERFLOW;
`ifdef ODO_TIMEOUT_TAG_EN
  logic              RD_TIMEOUT;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  odometer_capture_fifo #(
    .CNT_W(CNT_W),
    .DEPTH(DEPTH),
    .DZ_W (DZ_W)
  ) dut (
    .CLK       (CLK),
    .RESETB    (RESETB),
    .DETECT    (DETECT),
    .BF_COUNTER(BF_COUNTER),
    .ARM       (ARM),
    .RD_EN     (RD_EN),
    .CLR_OVF   (CLR_OVF),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
`ifdef ODO_TIMEOUT_TAG_EN
    .RD_TIMEOUT(RD_TIMEOUT),
`endif
    .EMPTY     (EMPTY),
    .FULL      (FULL),
    .LEVEL     (LEVEL),
    .OVERFLOW  (OVERFLOW)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Raise DETECT long enough to pass the synchroniser, then drop it. The
  // push lands on the 3rd edge after the fall, which is the last tick here.
  // pop_too / clr_too assert RD_EN / CLR_OVF in the fall_evt cycle.
  task automatic detect_fall(input logic [CNT_W-1:0] v, input bit pop_too,
                             input bit clr_too);
    BF_COUNTER = v;
    DETECT = 1'b1;
    ticks(3);
    DETECT = 1'b0;
    ticks(2);
    RD_EN   = pop_too;
    CLR_OVF = clr_too;
    tick();
    RD_EN   = 1'b0;
    CLR_OVF = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [CNT_W-1:0] exp,
                           input bit exp_tag);
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    check_val({tag, "_valid"}, 32'(RD_VALID), 32'd1);
    check_val({tag, "_data"}, 32'(RD_DATA), 32'(exp));
`ifdef ODO_TIMEOUT_TAG_EN
    check_val({tag, "_tag"}, 32'(RD_TIMEOUT), 32'(exp_tag));
`else
    if (exp_tag) begin end
`endif
  endtask

  initial begin
    // ---------------- reset state ----------------
    ticks(3);
    check_val("rst_empty", 32'(EMPTY), 32'd1);
    check_val("rst_level", 32'(LEVEL), 32'd0);
    check_val("rst_full", 32'(FULL), 32'd0);
    check_val("rst_valid", 32'(RD_VALID), 32'd0);
    check_val("rst_data", 32'(RD_DATA), 32'd0);
    check_val("rst_ovf", 32'(OVERFLOW), 32'd0);
    RESETB = 1'b1;
    tick();

    // ---------------- single capture, 3-cycle latency ----------------
    DETECT = 1'b1;
    ticks(4);
    ARM = 1'b1;
    BF_COUNTER = 12'h2A5;
    DETECT = 1'b0;
    ticks(2);
    check_val("cap_lat2", 32'(LEVEL), 32'd0);
    tick();
    check_val("cap_lat3", 32'(LEVEL), 32'd1);
    ARM = 1'b0;
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    check_val("cap_valid", 32'(RD_VALID), 32'd1);
    check_val("cap_data", 32'(RD_DATA), 32'h2A5);
    check_val("cap_empty", 32'(EMPTY), 32'd1);
    tick();
    check_val("cap_valid_drop", 32'(RD_VALID), 32'd0);
    check_val("cap_data_hold", 32'(RD_DATA), 32'h2A5);

    // ---------------- read while empty ----------------
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    check_val("rd_empty_valid", 32'(RD_VALID), 32'd0);
    check_val("rd_empty_level", 32'(LEVEL), 32'd0);

    // ---------------- deadzone timeout ----------------
    ARM = 1'b1;
    ticks(14);
    check_val("dz_before", 32'(LEVEL), 32'd0);
    tick();
    check_val("dz_first", 32'(LEVEL), 32'd1);
    ticks(14);
    check_val("dz_mid", 32'(LEVEL), 32'd1);
    tick();
    check_val("dz_second", 32'(LEVEL), 32'd2);
    ARM = 1'b0;
    ticks(20);
    check_val("dz_disarm_hold", 32'(LEVEL), 32'd2);
    pop_check("dz_pop0", 12'hFFF, 1'b1);
    pop_check("dz_pop1", 12'hFFF, 1'b1);

    // ---------------- collision: fall_evt on expiry cycle ----------------
    DETECT = 1'b1;
    ticks(4);
    BF_COUNTER = 12'h5C3;
    ARM = 1'b1;
    ticks(12);
    DETECT = 1'b0;
    ticks(2);
    check_val("col_before", 32'(LEVEL), 32'd0);
    tick();
    check_val("col_single", 32'(LEVEL), 32'd1);
    ticks(14);
    check_val("col_restart_mid", 32'(LEVEL), 32'd1);
    tick();
    check_val("col_restart_to", 32'(LEVEL), 32'd2);
    ARM = 1'b0;
    pop_check("col_pop0", 12'h5C3, 1'b0);
    pop_check("col_pop1", 12'hFFF, 1'b1);

    // ---------------- disarmed detection ignored ----------------
    detect_fall(12'h777, 1'b0, 1'b0);
    check_val("disarm_level", 32'(LEVEL), 32'd0);
    check_val("disarm_empty", 32'(EMPTY), 32'd1);

    // ---------------- push into empty with same-cycle RD_EN ----------------
    ARM = 1'b1;
    detect_fall(12'h0AB, 1'b1, 1'b0);
    check_val("pe_valid", 32'(RD_VALID), 32'd0);
    check_val("pe_level", 32'(LEVEL), 32'd1);
    ARM = 1'b0;
    pop_check("pe_pop", 12'h0AB, 1'b0);

    // ---------------- overflow: 5 pushes into depth 4 ----------------
    ARM = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      detect_fall(12'(i), 1'b0, 1'b0);
      if (i == 4) check_val("ovf_at4", 32'(OVERFLOW), 32'd0);
    end
    ARM = 1'b0;
    check_val("ovf_level", 32'(LEVEL), 32'd4);
    check_val("ovf_full", 32'(FULL), 32'd1);
    check_val("ovf_flag", 32'(OVERFLOW), 32'd1);
    for (int i = 1; i <= 4; i++) pop_check("ovf_pop", 12'(i), 1'b0);
    check_val("ovf_empty", 32'(EMPTY), 32'd1);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    check_val("ovf_clr", 32'(OVERFLOW), 32'd0);

    // ---------------- full with simultaneous push and pop ----------------
    ARM = 1'b1;
    for (int i = 0; i < 4; i++) detect_fall(12'h010 + 12'(i), 1'b0, 1'b0);
    check_val("pp_full", 32'(FULL), 32'd1);
    detect_fall(12'h014, 1'b1, 1'b0);
    check_val("pp_valid", 32'(RD_VALID), 32'd1);
    check_val("pp_data", 32'(RD_DATA), 32'h010);
    check_val("pp_level", 32'(LEVEL), 32'd4);
    check_val("pp_ovf", 32'(OVERFLOW), 32'd0);
    // CLR_OVF in the same cycle as a dropped push wins.
    detect_fall(12'h015, 1'b0, 1'b1);
    check_val("clr_prio_ovf", 32'(OVERFLOW), 32'd0);
    check_val("clr_prio_level", 32'(LEVEL), 32'd4);
    detect_fall(12'h016, 1'b0, 1'b0);
    check_val("ovf_again", 32'(OVERFLOW), 32'd1);
    ARM = 1'b0;
    for (int i = 1; i <= 4; i++) pop_check("pp_pop", 12'h010 + 12'(i), 1'b0);

    // ---------------- asynchronous reset mid-operation ----------------
    ARM = 1'b1;
    for (int i = 0; i < 4; i++) detect_fall(12'h021 + 12'(i), 1'b0, 1'b0);
    ARM = 1'b0;
    pop_check("pre_rst_pop", 12'h021, 1'b0);
    check_val("pre_rst_level", 32'(LEVEL), 32'd3);
    #2;
    RESETB = 1'b0;
    #1;
    check_val("arst_empty", 32'(EMPTY), 32'd1);
    check_val("arst_level", 32'(LEVEL), 32'd0);
    check_val("arst_valid", 32'(RD_VALID), 32'd0);
    check_val("arst_ovf", 32'(OVERFLOW), 32'd0);
    check_val("arst_full", 32'(FULL), 32'd0);
    ticks(2);
    RESETB = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
